// File: rtl/pixel_stream_proc.sv
// Streaming RGB-to-grayscale pixel processor with per-line mode select.
// Two-stage pipeline (grayscale, then mode op) under a single global stall.
module pixel_stream_proc #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_r,
  input  logic [DATA_W-1:0]         in_g,
  input  logic [DATA_W-1:0]         in_b,
  input  logic                      in_sol,
  input  logic                      in_eol,
  input  logic [2:0]                mode,
  input  logic [DATA_W-1:0]         threshold_val,
  input  logic signed [DATA_W:0]    brightness_offset,
  input  logic [DATA_W-1:0]         contrast_lo,
  input  logic [SHIFT_W-1:0]        contrast_shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_pixel,
  output logic                      out_sol,
  output logic                      out_eol
);

  localparam int unsigned SUM_W = DATA_W + 8;
  localparam int unsigned SGN_W = DATA_W + 2;
  localparam int unsigned CON_W = DATA_W + (1 << SHIFT_W);
  localparam logic [DATA_W-1:0] MAXV = '1;

  localparam logic [2:0] MODE_GRAY   = 3'd0;
  localparam logic [2:0] MODE_BRIGHT = 3'd1;
  localparam logic [2:0] MODE_THRESH = 3'd2;
  localparam logic [2:0] MODE_DOWN   = 3'd3;
  localparam logic [2:0] MODE_CONTR  = 3'd4;
  localparam logic [2:0] MODE_SMOOTH = 3'd5;

  logic              adv;
  logic              accept;
  logic [SUM_W-1:0]  y_sum;
  logic [2:0]        beat_mode;

  logic [2:0]        mode_q;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_y_q;
  logic              s1_sol_q;
  logic              s1_eol_q;
  logic [2:0]        s1_mode_q;

  logic [DATA_W-1:0] hist1_q;
  logic [DATA_W-1:0] hist2_q;
  logic              ds_odd_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_pixel_q;
  logic              out_sol_q;
  logic              out_eol_q;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  // Stage 1: luma with truncating fixed-point weights (sum of weights = 256)
  assign y_sum = SUM_W'(in_r) * SUM_W'(77) + SUM_W'(in_g) * SUM_W'(150)
               + SUM_W'(in_b) * SUM_W'(29);
  assign beat_mode = in_sol ? mode : mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
      s1_sol_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_mode_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_y_q    <= y_sum[SUM_W-1:8];
        s1_sol_q  <= in_sol;
        s1_eol_q  <= in_eol;
        s1_mode_q <= beat_mode;
      end
      if (accept && in_sol) mode_q <= mode;
    end
  end

  // Stage 2 datapath
  logic signed [SGN_W-1:0] bright_sum;
  logic [DATA_W-1:0]       bright_pix;
  logic [DATA_W-1:0]       diff;
  logic [CON_W-1:0]        con_shift;
  logic [DATA_W-1:0]       con_pix;
  logic [DATA_W-1:0]       h1;
  logic [DATA_W-1:0]       h2;
  logic [DATA_W+1:0]       smooth_sum;
  logic                    ds_idx;
  logic                    emit;
  logic [DATA_W-1:0]       pix_d;

  assign bright_sum = $signed({2'b00, s1_y_q})
                    + $signed({brightness_offset[DATA_W], brightness_offset});
  assign diff       = s1_y_q - contrast_lo;
  assign con_shift  = CON_W'(diff) << contrast_shift;
  // A sol beat replicates itself into both taps so the line edge is not smeared
  assign h1         = s1_sol_q ? s1_y_q : hist1_q;
  assign h2         = s1_sol_q ? s1_y_q : hist2_q;
  assign smooth_sum = {2'b00, h2} + {1'b0, h1, 1'b0} + {2'b00, s1_y_q};
  assign ds_idx     = s1_sol_q ? 1'b0 : ds_odd_q;

  always_comb begin
    bright_pix = bright_sum[DATA_W-1:0];
    if (bright_sum[SGN_W-1])      bright_pix = '0;
    else if (bright_sum[SGN_W-2]) bright_pix = MAXV;

    con_pix = con_shift[DATA_W-1:0];
    if (s1_y_q <= contrast_lo)                 con_pix = '0;
    else if (con_shift[CON_W-1:DATA_W] != '0) con_pix = MAXV;
  end

  always_comb begin
    pix_d = s1_y_q;
    emit  = 1'b1;
    case (s1_mode_q)
      MODE_GRAY:   pix_d = s1_y_q;
      MODE_BRIGHT: pix_d = bright_pix;
      MODE_THRESH: pix_d = (s1_y_q >= threshold_val) ? MAXV : '0;
      MODE_DOWN:   emit  = ~ds_idx | s1_eol_q;
      MODE_CONTR:  pix_d = con_pix;
      MODE_SMOOTH: pix_d = smooth_sum[DATA_W+1:2];
      default:     pix_d = s1_y_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_sol_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      hist1_q     <= '0;
      hist2_q     <= '0;
      ds_odd_q    <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q & emit;
      if (s1_valid_q) begin
        hist2_q  <= h1;
        hist1_q  <= s1_y_q;
        ds_odd_q <= ~ds_idx;
        if (emit) begin
          out_pixel_q <= pix_d;
          out_sol_q   <= s1_sol_q;
          out_eol_q   <= s1_eol_q;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_sol   = out_sol_q;
  assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Testbench for pixel_stream_proc: vector table, framing corner cases and
// randomized lines against a line-level reference model.
module tb_pixel_stream_proc;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_r, in_g, in_b;
  logic              in_sol, in_eol;
  logic [2:0]        mode;
  logic [7:0]        threshold_val;
  logic signed [8:0] brightness_offset;
  logic [7:0]        contrast_lo;
  logic [2:0]        contrast_shift;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_pixel;
  logic              out_sol, out_eol;

  pixel_stream_proc #(.DATA_W(8), .SHIFT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_sol(in_sol), .in_eol(in_eol), .mode(mode),
    .threshold_val(threshold_val), .brightness_offset(brightness_offset),
    .contrast_lo(contrast_lo), .contrast_shift(contrast_shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_sol(out_sol), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, g, b, m, thr, off, lo, sh, exp;
  } vec_t;

  typedef struct {
    int r, g, b;
    bit sol, eol;
    int m;
  } beat_t;

  typedef struct {
    int pix;
    bit sol, eol;
  } obeat_t;

  int     tests = 0;
  int     fails = 0;
  beat_t  drv_q[$];
  obeat_t exp_q[$];
  int     cfg_off;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int thr, input int off, input int lo, input int sh);
    threshold_val     = 8'(thr);
    cfg_off           = off;
    brightness_offset = 9'(off);
    contrast_lo       = 8'(lo);
    contrast_shift    = 3'(sh);
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Reference: operate on a whole line at once from the behavioural rules
  task automatic model_line(input beat_t line[$]);
    int ys[$];
    int n, m, o, pm1, pm2;
    bit emit;
    obeat_t e;
    n = line.size();
    m = line[0].m;
    if (m > 5) m = 0;
    foreach (line[i]) ys.push_back((77 * line[i].r + 150 * line[i].g + 29 * line[i].b) / 256);
    for (int i = 0; i < n; i++) begin
      emit = 1'b1;
      o = ys[i];
      case (m)
        1: o = clamp(ys[i] + cfg_off);
        2: o = (ys[i] >= int'(threshold_val)) ? 255 : 0;
        3: emit = (i % 2 == 0) || (i == n - 1);
        4: o = (ys[i] <= int'(contrast_lo)) ? 0
             : clamp((ys[i] - int'(contrast_lo)) * (1 << contrast_shift));
        5: begin
          pm1 = (i >= 1) ? ys[i-1] : ys[0];
          pm2 = (i >= 2) ? ys[i-2] : ys[0];
          o = (pm2 + 2 * pm1 + ys[i]) / 4;
        end
        default: o = ys[i];
      endcase
      drv_q.push_back(line[i]);
      if (emit) begin
        e.pix = o; e.sol = (i == 0); e.eol = (i == n - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic gray_line(input int vals[$], input int m);
    beat_t b;
    foreach (vals[i]) begin
      b.r = vals[i]; b.g = vals[i]; b.b = vals[i];
      b.sol = (i == 0); b.eol = (i == vals.size() - 1); b.m = m;
      drv_q.push_back(b);
    end
  endtask

  task automatic push_exp(input int pix, input bit sol, input bit eol);
    obeat_t e;
    e.pix = pix; e.sol = sol; e.eol = eol;
    exp_q.push_back(e);
  endtask

  task automatic drive_beat(input beat_t b);
    in_valid = 1'b1;
    in_r = 8'(b.r); in_g = 8'(b.g); in_b = 8'(b.b);
    in_sol = b.sol; in_eol = b.eol;
    // mode on non-sol beats is noise that must be ignored
    mode = b.sol ? 3'(b.m) : 3'($urandom_range(7));
  endtask

  task automatic run_stream(input int rdy_pct, input int budget);
    int cyc;
    bit have;
    beat_t b;
    obeat_t e;
    cyc = 0; have = 1'b0;
    while ((drv_q.size() > 0 || exp_q.size() > 0 || have) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(99) < rdy_pct);
      if (!have && drv_q.size() > 0) begin
        b = drv_q.pop_front();
        have = 1'b1;
      end
      if (have) drive_beat(b);
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("out_pixel", int'(out_pixel), e.pix);
          check("out_sol", int'(out_sol), int'(e.sol));
          check("out_eol", int'(out_eol), int'(e.eol));
        end
      end
      if (in_valid && in_ready) have = 1'b0;
    end
    if (cyc >= budget) check("stream_timeout", 1, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drv_q.delete();
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("idle_after_stream", int'(out_valid), 0);
  endtask

  vec_t tbl[14];
  int   vals[$];
  beat_t line[$];
  beat_t bt;

  initial begin
    tbl[0]  = '{100, 150, 200, 0, 100,   20,   0, 0, 140};
    tbl[1]  = '{100, 150, 200, 1, 100,   20,   0, 0, 160};
    tbl[2]  = '{100, 150, 200, 2, 100,   20,   0, 0, 255};
    tbl[3]  = '{250, 120,  60, 0, 100,   20,   0, 0, 152};
    tbl[4]  = '{250, 120,  60, 1, 100,   20,   0, 0, 172};
    tbl[5]  = '{250, 120,  60, 2, 100,   20,   0, 0, 255};
    tbl[6]  = '{250, 250, 250, 1, 100,   20,   0, 0, 255};
    tbl[7]  = '{ 10,  10,  10, 1, 100, -128,   0, 0,   0};
    tbl[8]  = '{140, 140, 140, 4, 100,    0, 100, 1,  80};
    tbl[9]  = '{152, 152, 152, 4, 100,    0, 100, 1, 104};
    tbl[10] = '{ 90,  90,  90, 4, 100,    0, 100, 1,   0};
    tbl[11] = '{250, 250, 250, 4, 100,    0, 100, 1, 255};
    tbl[12] = '{140, 140, 140, 2, 200,    0,   0, 0,   0};
    tbl[13] = '{100, 150, 200, 6, 100,   20,   0, 0, 140};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_r = '0; in_g = '0; in_b = '0; in_sol = 1'b0; in_eol = 1'b0; mode = '0;
    set_cfg(100, 20, 100, 1);
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_pixel", int'(out_pixel), 0);
    check("rst_out_sol", int'(out_sol), 0);
    check("rst_out_eol", int'(out_eol), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-pixel lines: exact two-cycle latency and per-mode values
    for (int i = 0; i < 14; i++) begin
      set_cfg(tbl[i].thr, tbl[i].off, tbl[i].lo, tbl[i].sh);
      bt.r = tbl[i].r; bt.g = tbl[i].g; bt.b = tbl[i].b;
      bt.sol = 1'b1; bt.eol = 1'b1; bt.m = tbl[i].m;
      drive_beat(bt);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d_latency1", i), int'(out_valid), 0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      check($sformatf("vec%0d_pixel", i), int'(out_pixel), tbl[i].exp);
      check($sformatf("vec%0d_sol_eol", i), int'({out_sol, out_eol}), 3);
    end
    @(negedge clk);

    // Smoothing with edge replicate
    vals = '{40, 80, 120};
    gray_line(vals, 5);
    push_exp(40, 1, 0); push_exp(50, 0, 0); push_exp(80, 0, 1);
    run_stream(100, 200);

    // Downsample, odd and even line lengths
    vals = '{10, 20, 30, 40, 50};
    gray_line(vals, 3);
    push_exp(10, 1, 0); push_exp(30, 0, 0); push_exp(50, 0, 1);
    vals = '{10, 20, 30, 40};
    gray_line(vals, 3);
    push_exp(10, 1, 0); push_exp(30, 0, 0); push_exp(40, 0, 1);
    vals = '{77};
    gray_line(vals, 3);
    push_exp(77, 1, 1);
    run_stream(100, 200);

    // Backpressure: stall with output valid, nothing accepted, pixel held
    vals = '{11, 12, 13, 14, 15, 16};
    gray_line(vals, 0);
    for (int i = 0; i < 6; i++) push_exp(11 + i, i == 0, i == 5);
    @(negedge clk); drive_beat(drv_q.pop_front()); out_ready = 1'b1;
    @(negedge clk); drive_beat(drv_q.pop_front());
    @(negedge clk); drive_beat(drv_q[0]); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_pixel", int'(out_pixel), 11);
      @(negedge clk);
    end
    run_stream(100, 200);

    // Reset mid-line drops in-flight beats; next line starts clean
    vals = '{200, 100, 50, 25};
    gray_line(vals, 5);
    @(negedge clk); drive_beat(drv_q.pop_front()); out_ready = 1'b1;
    @(negedge clk); drive_beat(drv_q.pop_front());
    @(negedge clk); drive_beat(drv_q.pop_front());
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_pixel", int'(out_pixel), 0);
    in_valid = 1'b0;
    drv_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    vals = '{40, 80, 120};
    gray_line(vals, 5);
    push_exp(40, 1, 0); push_exp(50, 0, 0); push_exp(80, 0, 1);
    run_stream(100, 200);

    // Randomized lines with random backpressure against the reference model
    for (int seg = 0; seg < 6; seg++) begin
      set_cfg($urandom_range(255), int'($urandom_range(511)) - 256,
              $urandom_range(255), $urandom_range(7));
      for (int l = 0; l < 6; l++) begin
        int n, m, v;
        n = $urandom_range(1, 9);
        m = $urandom_range(7);
        line.delete();
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(3) == 0) begin
            v = $urandom_range(255);
            bt.r = v; bt.g = v; bt.b = v;
          end else begin
            bt.r = $urandom_range(255); bt.g = $urandom_range(255); bt.b = $urandom_range(255);
          end
          bt.sol = (i == 0); bt.eol = (i == n - 1); bt.m = m;
          line.push_back(bt);
        end
        model_line(line);
      end
      run_stream(65, 3000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_stream_proc.md
Name: pixel_stream_proc

Overview:
Streaming, parametrised successor to the per-pixel image processor. Accepts one RGB pixel per beat on a valid/ready interface and converts it to grayscale. It then applies one of six modes: grayscale, brightness, threshold, 2:1 horizontal downsample, contrast stretch, or 3-tap horizontal smoothing. It sits between the pixel source (camera/frame reader) and the frame writer, with line framing carried by sol/eol sideband bits.

Parameters:
DATA_W, 8, bits per colour channel and per output pixel; max value MAXV = 2^DATA_W - 1.
SHIFT_W, 3, width of contrast gain shift field.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_r / in_g / in_b  in  DATA_W each  pixel colour channels
in_sol  in  1  first pixel of line
in_eol  in  1  last pixel of line
mode  in  3  operation select; sampled only on accepted in_sol beat
threshold_val  in  DATA_W  threshold level
brightness_offset  in  DATA_W+1 signed  brightness offset
contrast_lo  in  DATA_W  contrast black level
contrast_shift  in  SHIFT_W  contrast gain as left shift
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_pixel  out  DATA_W  processed pixel
out_sol / out_eol  out  1  framing aligned with out_pixel

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_pixel=0, out_sol=0, out_eol=0, latched mode=0, smoothing history=0, downsample index=0. A reset mid-line discards all in-flight beats.
- Two-stage pipeline (S1 grayscale, S2 mode op); latency 2 accepted-cycles from input beat to out_valid.
- Global stall: adv = ~out_valid | out_ready; in_ready = adv.
- When adv=0, both stages and all outputs hold; nothing is lost or duplicated.
- Beat accepted iff in_valid & in_ready.
- Grayscale: Y = (77*R + 150*G + 29*B) >> 8, using DATA_W+8 bit intermediate, truncating. When R=G=B=v, Y=v exactly.
- Mode latch: mode is captured on an accepted beat with in_sol=1 and applies to the whole line. Changes mid-line are ignored. Latched mode travels with each beat through the pipeline.
- Mode 0: out = Y.
- Mode 1: out = clamp(Y + brightness_offset, 0, MAXV), signed DATA_W+2 arithmetic.
- Mode 2: out = (Y >= threshold_val) ? MAXV : 0.
- Mode 3: per-line index counter resets on sol beat.
  - Even-indexed pixels are emitted; odd-indexed pixels are dropped (no out_valid).
  - Exception: a dropped pixel carrying eol instead emits its value with out_eol=1, so line framing is never lost.
  - out_sol is on index 0.
- Mode 4: out = (Y <= contrast_lo) ? 0 : clamp((Y - contrast_lo) << contrast_shift, MAXV).
- Mode 5: causal smoothing, out = (p[n-2] + 2*p[n-1] + p[n]) >> 2, DATA_W+2 bit sum.
  - On a sol beat, both history taps are loaded with that pixel (edge replicate).
  - History updates only on accepted beats, in every mode, so switching at the next sol is clean.
- Modes 6, 7: reserved; behave as mode 0.
- out_sol/out_eol are copies of the input flags delayed with the pixel, except as noted for mode 3.
- Simultaneous sol & eol (1-pixel line) is legal. Mode 3 emits it; mode 5 outputs that pixel.

Test Plan:
- Mode 0/1/2, threshold 100, offset +20. R=100,G=150,B=200 -> Y=140, brightness 160, threshold 255. R=250,G=120,B=60 -> Y=152, brightness 172, threshold 255. Each appears exactly 2 cycles after acceptance.
- Saturation on gray pixel v=250: offset +20 -> 255. On v=10: offset -128 -> 0.
- Mode 4, lo=100, shift=1. Gray inputs 140, 152, 90, 250 -> 80, 104, 0, 255.
- Mode 5, gray line 40, 80, 120 (sol on 40, eol on 120) -> 40, 50, 80, with out_sol on the first output and out_eol on the last.
- Mode 3, 5-pixel line 10..50 -> 10, 30, 50. A 4-pixel line 10..40 -> 10, 30, 40, with out_eol on 40.
- Backpressure: hold out_ready=0 for 3 cycles mid-line -> in_ready=0 and out_pixel stable throughout; the full sequence completes in order with no loss. Then assert rst_n=0 mid-line -> out_valid=0 immediately; the next line starts from clean history.
